cpu_nic: RTL and testbench

Memory-mapped network interface between the four-stage processor's data-memory port and a mesh router port. The processor reads and writes four 64-bit registers through the same enable/write-enable/address/data handshake it uses for dmem. The block drains an output FIFO toward the router and fills an input FIFO from the router using a valid/ready handshake. It is the responder end of the processor's data bus and the endpoint that injects and ejects packets on the mesh.

---
 rtl/cpu_nic.sv | 63 ++++++
 tb/tb_cpu_nic.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_nic.sv
// cpu_nic: memory-mapped NIC bridging the processor data bus and a mesh router port.
// Two DEPTH-entry FIFOs; full/empty decisions use pre-edge counts only.
module cpu_nic #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        nicEn,
  input  logic        nicWrEn,
  input  logic [0:63] d_in,
  output logic [0:63] d_out,
  input  logic        net_si,
  output logic        net_ri,
  input  logic [0:63] net_di,
  output logic        net_so,
  input  logic        net_ro,
  output logic [0:63] net_do
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [0:63] in_mem [DEPTH];
  logic [0:63] out_mem [DEPTH];
  logic [AW-1:0] in_rp, in_wp, out_rp, out_wp;
  logic [CW-1:0] in_cnt, out_cnt;
  logic rd, in_push, in_pop, out_push, out_pop;
  assign rd       = nicEn && !nicWrEn;
  assign net_ri   = in_cnt != FULL;
  assign net_so   = out_cnt != '0;
  assign in_push  = net_si && net_ri;
  assign in_pop   = rd && addr == 2'd0 && in_cnt != '0;
  assign out_push = nicEn && nicWrEn && addr == 2'd2 && out_cnt != FULL;
  assign out_pop  = net_so && net_ro;
  assign net_do   = net_so ? out_mem[out_rp] : '0;
  always_comb
    d_out = !rd            ? '0 :
            addr == 2'd0   ? (in_cnt != '0 ? in_mem[in_rp] : '0) :
            addr == 2'd1   ? 64'({in_cnt, in_cnt != '0}) :
            addr == 2'd3   ? 64'({out_cnt, out_cnt == FULL}) : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      in_rp   <= '0;
      in_wp   <= '0;
      in_cnt  <= '0;
      out_rp  <= '0;
      out_wp  <= '0;
      out_cnt <= '0;
    end else begin
      if (in_push) in_wp <= in_wp + AW'(1);
      if (in_pop) in_rp <= in_rp + AW'(1);
      if (out_push) out_wp <= out_wp + AW'(1);
      if (out_pop) out_rp <= out_rp + AW'(1);
      in_cnt  <= in_cnt + CW'(in_push) - CW'(in_pop);
      out_cnt <= out_cnt + CW'(out_push) - CW'(out_pop);
    end
  end
  // RAM contents are not reset; pointers alone define validity
  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wp] <= net_di;
    if (out_push) out_mem[out_wp] <= d_in;
  end
endmodule

// File: tb/tb_cpu_nic.sv
// tb_cpu_nic: queue-based reference model with a negedge monitor checking every cycle.
module tb_cpu_nic;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] addr;
  logic nicEn, nicWrEn, net_si, net_ri, net_so, net_ro;
  logic [0:63] d_in, d_out, net_di, net_do;
  int tests = 0;
  int fails = 0;
  bit live = 0;
  logic [63:0] qi[$];
  logic [63:0] qo[$];
  bit ip, ipop, op, opop;

  cpu_nic #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .addr(addr), .nicEn(nicEn), .nicWrEn(nicWrEn),
    .d_in(d_in), .d_out(d_out), .net_si(net_si), .net_ri(net_ri), .net_di(net_di),
    .net_so(net_so), .net_ro(net_ro), .net_do(net_do)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Reference: FIFOs as queues, decisions from sizes before the edge
  always @(posedge clk) begin
    if (reset) begin
      qi.delete();
      qo.delete();
      live = 1;
    end else begin
      ip   = net_si && qi.size() != DEPTH;
      ipop = nicEn && !nicWrEn && addr == 2'd0 && qi.size() != 0;
      op   = nicEn && nicWrEn && addr == 2'd2 && qo.size() != DEPTH;
      opop = net_ro && qo.size() != 0;
      if (ipop) void'(qi.pop_front());
      if (ip) qi.push_back(net_di);
      if (opop) void'(qo.pop_front());
      if (op) qo.push_back(d_in);
    end
  end

  function automatic logic [63:0] exp_dout();
    if (!(nicEn && !nicWrEn)) return 64'h0;
    case (addr)
      2'd0:    return qi.size() != 0 ? qi[0] : 64'h0;
      2'd1:    return 64'(qi.size() * 2 + int'(qi.size() != 0));
      2'd2:    return 64'h0;
      default: return 64'(qo.size() * 2 + int'(qo.size() == DEPTH));
    endcase
  endfunction

  always @(negedge clk) begin
    if (live) begin
      chk("net_ri", 64'(net_ri), 64'(qi.size() != DEPTH));
      chk("net_so", 64'(net_so), 64'(qo.size() != 0));
      if (qo.size() != 0) chk("net_do", net_do, qo[0]);
      chk("d_out", d_out, exp_dout());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a);
    nicEn = 1; nicWrEn = 0; addr = a;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    nicEn = 1; nicWrEn = 1; addr = a; d_in = d;
  endtask

  task automatic nop();
    nicEn = 0; nicWrEn = 0; addr = 0;
  endtask

  initial begin
    int n;
    {nicEn, nicWrEn, net_si, net_ro} = '0;
    addr = 0; d_in = 0; net_di = 0; reset = 1;
    step(); step();
    reset = 0;
    #1;
    chk("rst_ri", 64'(net_ri), 64'h1);
    chk("rst_so", 64'(net_so), 64'h0);
    chk("rst_dout", d_out, 64'h0);
    rd(1); chk("idle_st1", d_out, 64'h0);
    rd(3); chk("idle_st3", d_out, 64'h0);
    step();
    // output path with router stalled
    wr(2, 64'hAAAA_0000_0000_0001);
    step(); nop(); #1;
    chk("out_so", 64'(net_so), 64'h1);
    repeat (3) begin
      chk("out_hold", net_do, 64'hAAAA_0000_0000_0001);
      step();
    end
    net_ro = 1;
    step(); net_ro = 0; #1;
    chk("out_drained", 64'(net_so), 64'h0);
    rd(3); chk("out_st3", d_out, 64'h0);
    step(); nop();
    // input path fill to full
    net_si = 1;
    for (int i = 0; i < 5; i++) begin
      net_di = 64'h1234 + 64'(i);
      step();
    end
    net_si = 0; #1;
    chk("in_full_ri", 64'(net_ri), 64'h0);
    rd(1); chk("in_st_full", d_out, 64'h9);
    for (int i = 0; i < 4; i++) begin
      rd(0); chk("in_pop", d_out, 64'h1234 + 64'(i));
      step();
    end
    rd(1); chk("in_st_empty", d_out, 64'h0);
    rd(0); chk("in_pop_empty", d_out, 64'h0);
    step(); nop();
    // output overflow
    for (int i = 0; i < 5; i++) begin
      wr(2, 64'hB00 + 64'(i));
      step();
    end
    nop(); rd(3); chk("ovf_st3", d_out, 64'h9);
    nop(); net_ro = 1; n = 0;
    repeat (6) begin
      #1;
      if (net_so) begin
        chk("ovf_order", net_do, 64'hB00 + 64'(n));
        n++;
      end
      step();
    end
    net_ro = 0;
    chk("ovf_count", 64'(n), 64'd4);
    // simultaneous push/pop on input FIFO
    net_si = 1; net_di = 64'hC0; step();
    net_di = 64'hC1; step();
    net_di = 64'hC2; rd(0); chk("sim_in_head", d_out, 64'hC0);
    step(); net_si = 0;
    rd(1); chk("sim_in_st", d_out, 64'h5);
    rd(0); chk("sim_in_c1", d_out, 64'hC1); step();
    rd(0); chk("sim_in_c2", d_out, 64'hC2); step();
    nop();
    // full output FIFO: write dropped while router pops
    for (int i = 0; i < 4; i++) begin
      wr(2, 64'hD0 + 64'(i));
      step();
    end
    wr(2, 64'hDEAD); net_ro = 1;
    step(); net_ro = 0;
    rd(3); chk("sim_out_st", d_out, 64'h6);
    nop(); net_ro = 1;
    for (int i = 1; i < 4; i++) begin
      #1; chk("sim_out_order", net_do, 64'hD0 + 64'(i));
      step();
    end
    net_ro = 0; #1;
    chk("sim_out_empty", 64'(net_so), 64'h0);
    // reset with both FIFOs partly full
    for (int i = 0; i < 3; i++) begin
      net_si = 1; net_di = 64'hE0 + 64'(i);
      wr(2, 64'hF0 + 64'(i));
      step();
    end
    net_si = 0; nop();
    rd(1); chk("pre_rst_st1", d_out, 64'h7);
    nop(); reset = 1;
    step(); reset = 0; #1;
    chk("mid_rst_so", 64'(net_so), 64'h0);
    chk("mid_rst_ri", 64'(net_ri), 64'h1);
    rd(1); chk("mid_rst_st1", d_out, 64'h0);
    rd(3); chk("mid_rst_st3", d_out, 64'h0);
    step(); nop();
    // randomized traffic, monitor compares against the queue model
    repeat (3000) begin
      nicEn   = $urandom_range(0, 1) == 1;
      nicWrEn = $urandom_range(0, 1) == 1;
      addr    = 2'($urandom_range(0, 3));
      d_in    = {$urandom, $urandom};
      net_si  = $urandom_range(0, 2) != 0;
      net_di  = {$urandom, $urandom};
      net_ro  = $urandom_range(0, 2) == 0;
      reset   = $urandom_range(0, 299) == 0;
      step();
    end
    reset = 0; net_si = 0; net_ro = 0; nop();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
